// File: rtl/sdram_rom_arbiter.sv
// N-channel ROM read arbiter with one-word tag caches, plus IOCTL download byte packer, in front of a 32-bit SDRAM port.
// Optional macro ROM_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (channel 0 highest).
module sdram_rom_arbiter #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned AW       = 23,
    parameter int unsigned DL_INDEX = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    i_ch_cs,
    input  logic [NUM_CH*AW-1:0] i_ch_addr,
    output logic [NUM_CH*32-1:0] o_ch_data,
    output logic [NUM_CH-1:0]    o_ch_valid,
    input  logic                 i_ioctl_download,
    input  logic                 i_ioctl_wr,
    input  logic [24:0]          i_ioctl_addr,
    input  logic [7:0]           i_ioctl_data,
    input  logic [15:0]          i_ioctl_index,
    output logic                 o_dl_overrun,
    output logic [AW-1:0]        o_sdram_addr,
    output logic [31:0]          o_sdram_data,
    output logic                 o_sdram_we,
    output logic                 o_sdram_req,
    input  logic                 i_sdram_ack,
    input  logic                 i_sdram_valid,
    input  logic [31:0]          i_sdram_q
);

    localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_DL} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_tag     [NUM_CH];
    logic [31:0]       r_ch_data [NUM_CH];
    logic [NUM_CH-1:0] r_tag_v;
    logic [GW-1:0]     r_grant;
    logic [AW-1:0]     r_rd_addr;
    logic              r_dl_prev;
    logic              r_dl_overrun;
    logic [23:0]       r_dl_buf;
    logic [31:0]       r_wr_data;
    logic [AW-1:0]     r_wr_addr;
    logic              r_pend;
    logic              r_sdram_req;
    logic              r_sdram_we;
    logic [AW-1:0]     r_sdram_addr;
    logic [31:0]       r_sdram_data;
`ifdef ROM_ARB_RR_EN
    logic [GW-1:0]     r_last_grant;
`endif

    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_miss;
    logic [GW-1:0]     w_grant;
    logic              w_any_miss;
    logic [AW-1:0]     w_addr_sel;
    logic              w_dl_rise;
    logic              w_byte_wr;
    logic              w_lane3;
    logic              w_wr_ack;
    logic              w_pend_next;
    logic              w_overrun_set;
    logic [31:0]       w_wr_data_next;
    logic [AW-1:0]     w_wr_addr_next;

    // Cache hit detection and data fan-out
    always_comb begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            w_hit[n] = i_ch_cs[n] & r_tag_v[n] & (r_tag[n] == i_ch_addr[n*AW +: AW]);
            o_ch_data[n*32 +: 32] = r_ch_data[n];
        end
    end

    assign w_miss     = i_ch_cs & ~w_hit;
    assign o_ch_valid = w_hit;

    always_comb begin
        w_grant    = '0;
        w_any_miss = 1'b0;
`ifdef ROM_ARB_RR_EN
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!w_any_miss && w_miss[(32'(r_last_grant) + k + 1) % NUM_CH]) begin
                w_any_miss = 1'b1;
                w_grant    = GW'((32'(r_last_grant) + k + 1) % NUM_CH);
            end
        end
`else
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_miss[i]) begin
                w_any_miss = 1'b1;
                w_grant    = GW'(i);
            end
        end
`endif
    end

    assign w_addr_sel = i_ch_addr[w_grant*AW +: AW];

    // Download byte packing and pending-write bookkeeping
    assign w_dl_rise      = i_ioctl_download & ~r_dl_prev;
    assign w_byte_wr      = i_ioctl_download & i_ioctl_wr & (i_ioctl_index == 16'(DL_INDEX));
    assign w_lane3        = w_byte_wr & (i_ioctl_addr[1:0] == 2'd3);
    assign w_wr_ack       = r_sdram_req & r_sdram_we & i_sdram_ack;
    assign w_pend_next    = w_lane3 | (r_pend & ~w_wr_ack);
    assign w_overrun_set  = w_lane3 & r_pend & ~w_wr_ack;
    assign w_wr_data_next = w_lane3 ? {i_ioctl_data, r_dl_buf} : r_wr_data;
    assign w_wr_addr_next = w_lane3 ? AW'(i_ioctl_addr[24:2]) : r_wr_addr;

    assign o_dl_overrun = r_dl_overrun;
    assign o_sdram_req  = r_sdram_req;
    assign o_sdram_we   = r_sdram_we;
    assign o_sdram_addr = r_sdram_addr;
    assign o_sdram_data = r_sdram_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tag        <= '{default: '0};
            r_ch_data    <= '{default: '0};
            r_tag_v      <= '0;
            r_grant      <= '0;
            r_rd_addr    <= '0;
            r_dl_prev    <= 1'b0;
            r_dl_overrun <= 1'b0;
            r_dl_buf     <= '0;
            r_wr_data    <= '0;
            r_wr_addr    <= '0;
            r_pend       <= 1'b0;
            r_sdram_req  <= 1'b0;
            r_sdram_we   <= 1'b0;
            r_sdram_addr <= '0;
            r_sdram_data <= '0;
`ifdef ROM_ARB_RR_EN
            r_last_grant <= GW'(NUM_CH - 1);
`endif
        end else begin
            r_dl_prev <= i_ioctl_download;
            if (w_dl_rise)          r_dl_overrun <= 1'b0;
            else if (w_overrun_set) r_dl_overrun <= 1'b1;

            if (w_dl_rise) begin
                r_dl_buf <= '0;
            end else if (w_byte_wr) begin
                case (i_ioctl_addr[1:0])
                    2'd0:    r_dl_buf[7:0]   <= i_ioctl_data;
                    2'd1:    r_dl_buf[15:8]  <= i_ioctl_data;
                    2'd2:    r_dl_buf[23:16] <= i_ioctl_data;
                    default: ;
                endcase
            end
            r_wr_data <= w_wr_data_next;
            r_wr_addr <= w_wr_addr_next;
            r_pend    <= w_pend_next;

            case (r_state)
                S_IDLE: begin
                    if (i_ioctl_download) begin
                        r_state      <= S_DL;
                        r_tag_v      <= '0;
                        r_sdram_req  <= w_pend_next;
                        r_sdram_we   <= w_pend_next;
                        r_sdram_addr <= w_wr_addr_next;
                        r_sdram_data <= w_wr_data_next;
                    end else if (w_any_miss) begin
                        r_state      <= S_RD_REQ;
                        r_grant      <= w_grant;
                        r_rd_addr    <= w_addr_sel;
                        r_sdram_req  <= 1'b1;
                        r_sdram_we   <= 1'b0;
                        r_sdram_addr <= w_addr_sel;
`ifdef ROM_ARB_RR_EN
                        r_last_grant <= w_grant;
`endif
                    end
                end
                S_RD_REQ: begin
                    if (i_sdram_ack) begin
                        r_state     <= S_RD_WAIT;
                        r_sdram_req <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    // Fill always stores the address latched at grant time
                    if (i_sdram_valid) begin
                        r_tag[r_grant]     <= r_rd_addr;
                        r_tag_v[r_grant]   <= 1'b1;
                        r_ch_data[r_grant] <= i_sdram_q;
                        r_state            <= S_IDLE;
                    end
                end
                S_DL: begin
                    r_tag_v      <= '0;
                    r_sdram_req  <= w_pend_next;
                    r_sdram_we   <= w_pend_next;
                    r_sdram_addr <= w_wr_addr_next;
                    r_sdram_data <= w_wr_data_next;
                    if (!i_ioctl_download && !w_pend_next) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Directed bench for sdram_rom_arbiter: table of cached reads plus hand sequences for arbitration, download and reset.
module tb_sdram_rom_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 23;

    logic               clk = 1'b0;
    logic               reset;
    logic [NCH-1:0]     ch_cs;
    logic [NCH*AW-1:0]  ch_addr;
    logic [NCH*32-1:0]  ch_data;
    logic [NCH-1:0]     ch_valid;
    logic               dl, wr;
    logic [24:0]        ioaddr;
    logic [7:0]         iodata;
    logic [15:0]        ioidx;
    logic               overrun;
    logic [AW-1:0]      s_addr;
    logic [31:0]        s_data;
    logic               s_we, s_req, s_ack, s_valid;
    logic [31:0]        s_q;

    int checks = 0;
    int errors = 0;

    sdram_rom_arbiter #(.NUM_CH(NCH), .AW(AW), .DL_INDEX(0)) dut (
        .clk(clk), .reset(reset),
        .i_ch_cs(ch_cs), .i_ch_addr(ch_addr), .o_ch_data(ch_data), .o_ch_valid(ch_valid),
        .i_ioctl_download(dl), .i_ioctl_wr(wr), .i_ioctl_addr(ioaddr),
        .i_ioctl_data(iodata), .i_ioctl_index(ioidx), .o_dl_overrun(overrun),
        .o_sdram_addr(s_addr), .o_sdram_data(s_data), .o_sdram_we(s_we), .o_sdram_req(s_req),
        .i_sdram_ack(s_ack), .i_sdram_valid(s_valid), .i_sdram_q(s_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [22:0] addr;
        logic [31:0] q;
        bit          hit;
    } rd_vec_t;

    rd_vec_t vecs[8];

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic cs, input logic [22:0] a);
        ch_cs[ch] = cs;
        ch_addr[ch*AW +: AW] = a;
    endtask

    // Starts on the cycle where a read request must be visible
    task automatic serve(input string nm, input logic [22:0] a, input logic [31:0] q);
        chk({nm, "_req"}, 64'(s_req), 64'd1);
        chk({nm, "_we"}, 64'(s_we), 64'd0);
        chk({nm, "_addr"}, 64'(s_addr), 64'(a));
        s_ack = 1'b1;
        step;
        s_ack = 1'b0;
        chk({nm, "_req_drop"}, 64'(s_req), 64'd0);
        step;
        step;
        s_valid = 1'b1;
        s_q     = q;
        step;
        s_valid = 1'b0;
        s_q     = '0;
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        wr = 1'b1; ioaddr = a; iodata = d;
        step;
        wr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, 23'h000100, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1, 23'h000100, 32'hDEADBEEF, 1'b1};
        vecs[2] = '{0, 23'h000200, 32'h12345678, 1'b0};
        vecs[3] = '{0, 23'h000200, 32'h12345678, 1'b1};
        vecs[4] = '{3, 23'h7FFFFF, 32'hA5A5A5A5, 1'b0};
        vecs[5] = '{1, 23'h000101, 32'hCAFEF00D, 1'b0};
        vecs[6] = '{1, 23'h000101, 32'hCAFEF00D, 1'b1};
        vecs[7] = '{2, 23'h000000, 32'h0BADF00D, 1'b0};

        reset = 1'b1; ch_cs = '0; ch_addr = '0; dl = 1'b0; wr = 1'b0;
        ioaddr = '0; iodata = '0; ioidx = '0; s_ack = 1'b0; s_valid = 1'b0; s_q = '0;
        step; step;
        chk("rst_req", 64'(s_req), 64'd0);
        chk("rst_we", 64'(s_we), 64'd0);
        chk("rst_valid", 64'(ch_valid), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_addr", 64'(s_addr), 64'd0);
        chk("rst_data", 64'(s_data), 64'd0);
        reset = 1'b0;
        step;

        for (int i = 0; i < 8; i++) begin
            set_ch(vecs[i].ch, 1'b1, vecs[i].addr);
            #1;
            if (vecs[i].hit) begin
                chk($sformatf("v%0d_hit", i), 64'(ch_valid[vecs[i].ch]), 64'd1);
                chk($sformatf("v%0d_hdata", i), 64'(ch_data[vecs[i].ch*32 +: 32]), 64'(vecs[i].q));
                step;
                chk($sformatf("v%0d_noreq", i), 64'(s_req), 64'd0);
            end else begin
                chk($sformatf("v%0d_miss", i), 64'(ch_valid[vecs[i].ch]), 64'd0);
                chk($sformatf("v%0d_req0", i), 64'(s_req), 64'd0);
                step;
                serve($sformatf("v%0d", i), vecs[i].addr, vecs[i].q);
                chk($sformatf("v%0d_fill", i), 64'(ch_valid[vecs[i].ch]), 64'd1);
                chk($sformatf("v%0d_fdata", i), 64'(ch_data[vecs[i].ch*32 +: 32]), 64'(vecs[i].q));
            end
            set_ch(vecs[i].ch, 1'b0, vecs[i].addr);
            step;
        end

        // Arbitration: ch0 granted last, then ch0 and ch2 miss together
        set_ch(0, 1'b1, 23'h000280);
        step;
        serve("arb_pre", 23'h000280, 32'h00000280);
        set_ch(0, 1'b1, 23'h000300);
        set_ch(2, 1'b1, 23'h000400);
        step;
`ifdef ROM_ARB_RR_EN
        serve("arb_first", 23'h000400, 32'h44440000);
        chk("arb_first_valid", 64'(ch_valid[2]), 64'd1);
        step;
        serve("arb_second", 23'h000300, 32'h33330000);
        chk("arb_second_valid", 64'(ch_valid[0]), 64'd1);
`else
        serve("arb_first", 23'h000300, 32'h33330000);
        chk("arb_first_valid", 64'(ch_valid[0]), 64'd1);
        step;
        serve("arb_second", 23'h000400, 32'h44440000);
        chk("arb_second_valid", 64'(ch_valid[2]), 64'd1);
`endif
        chk("arb_ch2_data", 64'(ch_data[2*32 +: 32]), 64'h44440000);
        ch_cs = '0;
        step;

        // Download of one full word
        dl = 1'b1; ioidx = 16'd0;
        step;
        dl_byte(25'h10, 8'h11);
        dl_byte(25'h11, 8'h22);
        dl_byte(25'h12, 8'h33);
        dl_byte(25'h13, 8'h44);
        chk("dl_req", 64'(s_req), 64'd1);
        chk("dl_we", 64'(s_we), 64'd1);
        chk("dl_addr", 64'(s_addr), 64'h4);
        chk("dl_data", 64'(s_data), 64'h44332211);
        step;
        chk("dl_req_hold", 64'(s_req), 64'd1);
        s_ack = 1'b1;
        step;
        s_ack = 1'b0;
        chk("dl_req_drop", 64'(s_req), 64'd0);
        chk("dl_we_drop", 64'(s_we), 64'd0);
        dl = 1'b0;
        step;
        chk("dl_no_overrun", 64'(overrun), 64'd0);

        // Foreign index ignored, then overrun on two unacknowledged words
        dl = 1'b1; ioidx = 16'd1;
        step;
        dl_byte(25'h10, 8'h11);
        dl_byte(25'h11, 8'h22);
        dl_byte(25'h12, 8'h33);
        dl_byte(25'h13, 8'h44);
        chk("idx1_noreq", 64'(s_req), 64'd0);
        ioidx = 16'd0;
        dl_byte(25'h20, 8'h01);
        dl_byte(25'h21, 8'h02);
        dl_byte(25'h22, 8'h03);
        dl_byte(25'h23, 8'h04);
        chk("ovr_first_data", 64'(s_data), 64'h04030201);
        chk("ovr_pre", 64'(overrun), 64'd0);
        dl_byte(25'h24, 8'h05);
        dl_byte(25'h25, 8'h06);
        dl_byte(25'h26, 8'h07);
        dl_byte(25'h27, 8'h08);
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_req", 64'(s_req), 64'd1);
        chk("ovr_addr", 64'(s_addr), 64'h9);
        chk("ovr_data", 64'(s_data), 64'h08070605);
        s_ack = 1'b1;
        step;
        s_ack = 1'b0;
        chk("ovr_req_drop", 64'(s_req), 64'd0);
        dl = 1'b0;
        step;
        step;
        chk("ovr_sticky", 64'(overrun), 64'd1);
        dl = 1'b1;
        step;
        chk("ovr_clear_rise", 64'(overrun), 64'd0);
        dl = 1'b0;
        step;
        step;

        // Download starts during RD_WAIT; post-download refetch
        set_ch(1, 1'b1, 23'h000500);
        step;
        chk("rw_req", 64'(s_req), 64'd1);
        s_ack = 1'b1;
        step;
        s_ack = 1'b0;
        dl = 1'b1;
        step;
        step;
        s_valid = 1'b1; s_q = 32'h55AA55AA;
        step;
        s_valid = 1'b0; s_q = '0;
        chk("rw_fill_valid", 64'(ch_valid[1]), 64'd1);
        chk("rw_fill_data", 64'(ch_data[1*32 +: 32]), 64'h55AA55AA);
        step;
        chk("rw_dl_inval", 64'(ch_valid), 64'd0);
        chk("rw_dl_noreq", 64'(s_req), 64'd0);
        step;
        chk("rw_dl_noreq2", 64'(s_req), 64'd0);
        dl = 1'b0;
        step;
        step;
        serve("refetch", 23'h000500, 32'h66666666);
        chk("refetch_valid", 64'(ch_valid[1]), 64'd1);
        chk("refetch_data", 64'(ch_data[1*32 +: 32]), 64'h66666666);
        ch_cs = '0;
        step;

        // Asynchronous reset while a read request is outstanding
        set_ch(3, 1'b1, 23'h000600);
        step;
        chk("rr_req", 64'(s_req), 64'd1);
        reset = 1'b1;
        #1;
        chk("rr_req_async", 64'(s_req), 64'd0);
        chk("rr_valid", 64'(ch_valid), 64'd0);
        chk("rr_data3", 64'(ch_data[3*32 +: 32]), 64'd0);
        step;
        reset = 1'b0;
        s_valid = 1'b1; s_q = 32'hFFFFFFFF;
        step;
        s_valid = 1'b0; s_q = '0;
        chk("rr_late_valid", 64'(ch_valid[3]), 64'd0);
        chk("rr_late_data", 64'(ch_data[3*32 +: 32]), 64'd0);
        chk("rr_rereq", 64'(s_req), 64'd1);
        chk("rr_rereq_addr", 64'(s_addr), 64'h600);
        ch_cs = '0;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
